cpu_mem_sched: RTL and testbench

//  Sequences one CPU step at a time over a single shared memory bus. Per step: instruction fetch, then optional data read/write, then a 1-cycle o_cpu_clk_ce pulse.

---
 rtl/cpu_mem_sched_pkg.sv | 21 ++
 rtl/cpu_mem_sched_bus_timeout.sv | 35 +++
 rtl/cpu_mem_sched.sv | 133 +++++++++++++
 tb/tb_cpu_mem_sched.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_sched_pkg.sv
// Shared state encoding, parameter defaults and address helper for the
// CPU/memory step scheduler.
package cpu_mem_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DATA  = 3'd2,
        ST_STEP  = 3'd3,
        ST_HALT  = 3'd4
    } sched_state_t;

    localparam int          DEFAULT_TIMEOUT   = 16;
    localparam logic [31:0] DEFAULT_KILL_ADDR = 32'h0001_0000;
    localparam logic [31:0] DEFAULT_NOP_INSN  = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/cpu_mem_sched_bus_timeout.sv
// Per-phase wait counter: expires on the TIMEOUT-th consecutive cycle without
// an ack. A TIMEOUT of 0 disables expiry altogether.
module cpu_mem_sched_bus_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (count) begin
                    cnt <= cnt + CW'(1);
                end
            end

            // The cycle that would bring the count up to TIMEOUT is the expiring one.
            assign expire = count && (cnt == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/cpu_mem_sched.sv
// Steps the CPU one instruction at a time over one shared memory bus:
// instruction fetch, optional data access, then a one-cycle clock-enable pulse.
module cpu_mem_sched
    import cpu_mem_sched_pkg::*;
#(
    parameter int          TIMEOUT   = DEFAULT_TIMEOUT,
    parameter logic [31:0] KILL_ADDR = DEFAULT_KILL_ADDR,
    parameter logic [31:0] NOP_INSN  = DEFAULT_NOP_INSN
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_cpu_addr_i,
    output logic [31:0] o_cpu_data_i,
    input  logic [31:0] i_cpu_addr_d,
    input  logic        i_cpu_rd_d,
    input  logic [3:0]  i_cpu_wr_d,
    input  logic [31:0] i_cpu_data_wr_d,
    output logic [31:0] o_cpu_data_rd_d,
    output logic        o_cpu_clk_ce,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_wr,
    output logic [31:0] o_mem_data_wr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data_rd,
    output logic        o_bus_err,
    output logic        o_halt
);

    sched_state_t state;
    logic [31:0]  snap_addr_d;
    logic [31:0]  snap_data_wr;
    logic         snap_rd;
    logic [3:0]   snap_wr;
    logic         in_phase;
    logic         expire;
    logic         done;
    logic         has_data;

    assign in_phase = (state == ST_FETCH) || (state == ST_DATA);
    assign done     = in_phase && (i_mem_ack || expire);
    assign has_data = snap_rd || (snap_wr != 4'b0000);

    // Restarting on every phase end gives a DATA phase its own full wait budget.
    cpu_mem_sched_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clear  (!in_phase || done),
        .count  (in_phase && !i_mem_ack),
        .expire (expire)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= ST_IDLE;
            snap_addr_d     <= '0;
            snap_data_wr    <= '0;
            snap_rd         <= 1'b0;
            snap_wr         <= '0;
            o_cpu_data_i    <= '0;
            o_cpu_data_rd_d <= '0;
            o_cpu_clk_ce    <= 1'b0;
            o_mem_req       <= 1'b0;
            o_mem_addr      <= '0;
            o_mem_wr        <= '0;
            o_mem_data_wr   <= '0;
            o_bus_err       <= 1'b0;
            o_halt          <= 1'b0;
        end else begin
            o_cpu_clk_ce <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_cpu_addr_i == KILL_ADDR) begin
                        o_halt <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        snap_addr_d  <= i_cpu_addr_d;
                        snap_data_wr <= i_cpu_data_wr_d;
                        snap_rd      <= i_cpu_rd_d;
                        snap_wr      <= i_cpu_wr_d;
                        o_mem_req    <= 1'b1;
                        o_mem_addr   <= word_align(i_cpu_addr_i);
                        o_mem_wr     <= 4'b0000;
                        state        <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (done) begin
                        o_cpu_data_i <= i_mem_ack ? i_mem_data_rd : NOP_INSN;
                        if (!i_mem_ack) begin
                            o_bus_err <= 1'b1;
                        end
                        // A data access follows back-to-back so a zero-wait step with data costs 4 cycles.
                        if (has_data) begin
                            o_mem_addr    <= word_align(snap_addr_d);
                            o_mem_wr      <= snap_wr;
                            o_mem_data_wr <= snap_data_wr;
                            state         <= ST_DATA;
                        end else begin
                            o_mem_req    <= 1'b0;
                            o_cpu_clk_ce <= 1'b1;
                            state        <= ST_STEP;
                        end
                    end
                end
                ST_DATA: begin
                    if (done) begin
                        o_cpu_data_rd_d <= (i_mem_ack && snap_rd) ? i_mem_data_rd : 32'h0;
                        if (!i_mem_ack) begin
                            o_bus_err <= 1'b1;
                        end
                        o_mem_req    <= 1'b0;
                        o_mem_wr     <= 4'b0000;
                        o_cpu_clk_ce <= 1'b1;
                        state        <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    state <= ST_IDLE;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_sched.sv
// Randomised and directed bench for cpu_mem_sched: a variable-latency RAM slave
// plus a step-level reference model of fetch/data/timeout/halt behaviour.
module tb_cpu_mem_sched;

    localparam int          TO       = 16;
    localparam logic [31:0] KILL     = 32'h0001_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          NEVER    = 1000;

    logic        clk;
    logic        rst_n;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_addr_d;
    logic        cpu_rd_d;
    logic [3:0]  cpu_wr_d;
    logic [31:0] cpu_data_wr_d;
    logic        mem_ack;
    logic [31:0] mem_data_rd;
    logic [31:0] o_cpu_data_i;
    logic [31:0] o_cpu_data_rd_d;
    logic        o_cpu_clk_ce;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_wr;
    logic [31:0] o_mem_data_wr;
    logic        o_bus_err;
    logic        o_halt;

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] ref_insn;
    logic [31:0] ref_rd;
    logic        ref_err;
    int          fetch_lat;
    int          data_lat;
    bit          spurious;
    bit          at_idle;
    int          checks;
    int          errors;

    cpu_mem_sched #(
        .TIMEOUT   (TO),
        .KILL_ADDR (KILL),
        .NOP_INSN  (NOP)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_cpu_addr_i    (cpu_addr_i),
        .o_cpu_data_i    (o_cpu_data_i),
        .i_cpu_addr_d    (cpu_addr_d),
        .i_cpu_rd_d      (cpu_rd_d),
        .i_cpu_wr_d      (cpu_wr_d),
        .i_cpu_data_wr_d (cpu_data_wr_d),
        .o_cpu_data_rd_d (o_cpu_data_rd_d),
        .o_cpu_clk_ce    (o_cpu_clk_ce),
        .o_mem_req       (o_mem_req),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wr        (o_mem_wr),
        .o_mem_data_wr   (o_mem_data_wr),
        .i_mem_ack       (mem_ack),
        .i_mem_data_rd   (mem_data_rd),
        .o_bus_err       (o_bus_err),
        .o_halt          (o_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM slave: acks the first transaction of a step after fetch_lat wait cycles,
    // a back-to-back second one after data_lat; byte writes land on the ack cycle.
    initial begin
        int wait_cnt;
        int txn_idx;
        int lat;
        mem_ack     = 1'b0;
        mem_data_rd = 32'h0;
        wait_cnt    = 0;
        txn_idx     = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (o_mem_req === 1'b1) begin
                lat = (txn_idx == 0) ? fetch_lat : data_lat;
                if (wait_cnt == lat) begin
                    mem_ack     = 1'b1;
                    mem_data_rd = ram[o_mem_addr[9:2]];
                    for (int b = 0; b < 4; b++) begin
                        if (o_mem_wr[b]) begin
                            ram[o_mem_addr[9:2]][8*b +: 8] = o_mem_data_wr[8*b +: 8];
                        end
                    end
                    txn_idx  = txn_idx + 1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                wait_cnt = 0;
                txn_idx  = 0;
                if (spurious) begin
                    mem_ack     = 1'b1;
                    mem_data_rd = 32'hBAD0_BAD0;
                end
            end
        end
    end

    function automatic int phase_len(input int lat);
        return (lat < TO) ? lat + 1 : TO;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] val,
                                                input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) r[8*b +: 8] = val[8*b +: 8];
        end
        return r;
    endfunction

    // One CPU step: updates the reference model, then checks the bus cycle by cycle
    // (fetch phase, data phase, ce pulse) and the held outputs at the end.
    task automatic run_step(input string tag, input logic [31:0] a_i, input logic [31:0] a_d,
                            input logic rd, input logic [3:0] wr, input logic [31:0] dw,
                            input int lat_f, input int lat_d);
        int          f;
        int          d;
        bit          has_data;
        bit          cmp_dw;
        logic        e_req;
        logic        e_ce;
        logic [31:0] e_addr;
        logic [3:0]  e_wr;
        logic [69:0] obs;
        logic [69:0] exp;
        has_data = rd || (wr != 4'b0000);
        f = phase_len(lat_f);
        d = has_data ? phase_len(lat_d) : 0;
        if (lat_f < TO) begin
            ref_insn = ref_mem[a_i[9:2]];
        end else begin
            ref_insn = NOP;
            ref_err  = 1'b1;
        end
        if (has_data) begin
            if (lat_d < TO) begin
                ref_rd = rd ? ref_mem[a_d[9:2]] : 32'h0;
                ref_mem[a_d[9:2]] = merge_bytes(ref_mem[a_d[9:2]], dw, wr);
            end else begin
                ref_rd  = 32'h0;
                ref_err = 1'b1;
            end
        end
        cpu_addr_i    = a_i;
        cpu_addr_d    = a_d;
        cpu_rd_d      = rd;
        cpu_wr_d      = wr;
        cpu_data_wr_d = dw;
        fetch_lat     = lat_f;
        data_lat      = lat_d;
        if (!at_idle) begin
            @(posedge clk);
            #1;
            checks++;
            if ({o_mem_req, o_cpu_clk_ce} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL %s idle_gap req/ce got %b%b expected 00", tag, o_mem_req, o_cpu_clk_ce);
            end
        end
        at_idle = 1'b0;
        for (int s = 1; s <= f + d + 1; s++) begin
            @(posedge clk);
            #1;
            cmp_dw = 1'b0;
            if (s <= f) begin
                e_req = 1'b1; e_ce = 1'b0; e_addr = a_i & 32'hFFFF_FFFC; e_wr = 4'b0000;
            end else if (s <= f + d) begin
                e_req = 1'b1; e_ce = 1'b0; e_addr = a_d & 32'hFFFF_FFFC; e_wr = wr;
                cmp_dw = (wr != 4'b0000);
            end else begin
                e_req = 1'b0; e_ce = 1'b1; e_addr = 32'h0; e_wr = 4'b0000;
            end
            obs = {o_mem_req, o_cpu_clk_ce, e_req ? o_mem_addr : 32'h0, e_req ? o_mem_wr : 4'h0,
                   cmp_dw ? o_mem_data_wr : 32'h0};
            exp = {e_req, e_ce, e_addr, e_wr, cmp_dw ? dw : 32'h0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL %s bus cycle %0d got req=%b ce=%b addr=%h wr=%b dw=%h expected req=%b ce=%b addr=%h wr=%b dw=%h",
                         tag, s, o_mem_req, o_cpu_clk_ce, o_mem_addr, o_mem_wr, o_mem_data_wr,
                         e_req, e_ce, e_addr, e_wr, dw);
            end
        end
        checks++;
        if ({o_cpu_data_i, o_cpu_data_rd_d, o_bus_err, o_halt} !== {ref_insn, ref_rd, ref_err, 1'b0}) begin
            errors++;
            $display("[TB] FAIL %s step_outputs got insn=%h rd=%h err=%b halt=%b expected insn=%h rd=%h err=%b halt=0",
                     tag, o_cpu_data_i, o_cpu_data_rd_d, o_bus_err, o_halt, ref_insn, ref_rd, ref_err);
        end
        if (wr != 4'b0000) begin
            checks++;
            if (ram[a_d[9:2]] !== ref_mem[a_d[9:2]]) begin
                errors++;
                $display("[TB] FAIL %s ram_word got %h expected %h", tag, ram[a_d[9:2]], ref_mem[a_d[9:2]]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_mem_req, o_cpu_clk_ce, o_mem_addr, o_mem_wr, o_mem_data_wr, o_cpu_data_i,
             o_cpu_data_rd_d, o_bus_err, o_halt} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got req=%b ce=%b addr=%h insn=%h rd=%h err=%b halt=%b expected all 0",
                     o_mem_req, o_cpu_clk_ce, o_mem_addr, o_cpu_data_i, o_cpu_data_rd_d, o_bus_err, o_halt);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        ref_insn = 32'h0;
        ref_rd   = 32'h0;
        ref_err  = 1'b0;
        at_idle  = 1'b1;
    endtask

    task automatic test_addi_loop();
        logic [31:0] prog [5];
        prog[0] = 32'h0010_0093; prog[1] = 32'h0010_8093; prog[2] = 32'h0020_8093;
        prog[3] = 32'h0030_8093; prog[4] = 32'h0040_8093;
        for (int i = 0; i < 5; i++) begin
            ram[i] = prog[i];
            ref_mem[i] = prog[i];
        end
        for (int i = 0; i < 5; i++) begin
            run_step("addi_loop", 32'(i) << 2, 32'h0, 1'b0, 4'b0000, 32'h0, 0, 0);
            checks++;
            if (o_cpu_data_i !== prog[i]) begin
                errors++;
                $display("[TB] FAIL addi_insn got %h expected %h", o_cpu_data_i, prog[i]);
            end
        end
    endtask

    task automatic test_store();
        ram[64]     = 32'h1122_3344;
        ref_mem[64] = 32'h1122_3344;
        run_step("store", 32'h20, 32'h100, 1'b0, 4'b0011, 32'hDEAD_BEEF, 0, 0);
        checks++;
        if ({ram[64], o_cpu_data_rd_d} !== {32'h1122_BEEF, 32'h0}) begin
            errors++;
            $display("[TB] FAIL store_result got ram=%h rd=%h expected ram=1122beef rd=00000000",
                     ram[64], o_cpu_data_rd_d);
        end
    endtask

    task automatic test_delayed_load();
        run_step("load_delay3", 32'h24, 32'h100, 1'b1, 4'b0000, 32'h0, 0, 3);
        checks++;
        if (o_cpu_data_rd_d !== 32'h1122_BEEF) begin
            errors++;
            $display("[TB] FAIL load_value got %h expected 1122beef", o_cpu_data_rd_d);
        end
    endtask

    task automatic test_ack_at_limit();
        run_step("ack_at_16", 32'h28, 32'h0, 1'b0, 4'b0000, 32'h0, TO - 1, 0);
        run_step("ack_at_16_data", 32'h2C, 32'h104, 1'b1, 4'b1111, 32'hCAFE_F00D, 0, TO - 1);
    endtask

    task automatic test_spurious_ack();
        spurious = 1'b1;
        run_step("spurious_ack", 32'h30, 32'h108, 1'b1, 4'b0000, 32'h0, 1, 0);
        run_step("spurious_ack2", 32'h34, 32'h0, 1'b0, 4'b0000, 32'h0, 0, 0);
        spurious = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a_i;
        logic [31:0] a_d;
        logic        rd;
        logic [3:0]  wr;
        for (int n = 0; n < 25; n++) begin
            a_i = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
            a_d = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
            rd  = 1'($urandom_range(0, 1));
            wr  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0000;
            run_step("random", a_i, a_d, rd, wr, $urandom,
                     int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
        end
    endtask

    task automatic test_timeout();
        run_step("timeout_fetch", 32'h38, 32'h0, 1'b0, 4'b0000, 32'h0, NEVER, 0);
        checks++;
        if ({o_cpu_data_i, o_bus_err} !== {NOP, 1'b1}) begin
            errors++;
            $display("[TB] FAIL timeout_nop got insn=%h err=%b expected insn=%h err=1", o_cpu_data_i, o_bus_err, NOP);
        end
        run_step("timeout_data", 32'h3C, 32'h10C, 1'b1, 4'b1111, 32'h5555_AAAA, 0, NEVER);
        run_step("err_sticky", 32'h40, 32'h10C, 1'b1, 4'b0000, 32'h0, 0, 0);
    endtask

    task automatic test_reset_mid_data();
        cpu_addr_i = 32'h44; cpu_addr_d = 32'h110; cpu_rd_d = 1'b1; cpu_wr_d = 4'b0101;
        cpu_data_wr_d = 32'h1234_5678; fetch_lat = 0; data_lat = NEVER;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_mem_req, o_mem_wr} !== {1'b1, 4'b0101}) begin
            errors++;
            $display("[TB] FAIL pre_reset_data got req=%b wr=%b expected req=1 wr=0101", o_mem_req, o_mem_wr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_mem_req, o_cpu_clk_ce, o_mem_addr, o_mem_wr, o_mem_data_wr, o_cpu_data_i,
             o_cpu_data_rd_d, o_bus_err, o_halt} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset got req=%b ce=%b wr=%b insn=%h rd=%h err=%b expected all 0",
                     o_mem_req, o_cpu_clk_ce, o_mem_wr, o_cpu_data_i, o_cpu_data_rd_d, o_bus_err);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        ref_insn = 32'h0;
        ref_rd   = 32'h0;
        ref_err  = 1'b0;
        at_idle  = 1'b1;
        run_step("restart_pc0", 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 0, 0);
    endtask

    task automatic test_halt();
        int bad;
        cpu_addr_i = KILL; cpu_rd_d = 1'b0; cpu_wr_d = 4'b0000;
        @(posedge clk);
        #1;
        checks++;
        if ({o_halt, o_mem_req} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL halt_idle got halt=%b req=%b expected 00", o_halt, o_mem_req);
        end
        @(posedge clk);
        #1;
        checks++;
        if (o_halt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL halt_set got %b expected 1", o_halt);
        end
        spurious   = 1'b1;
        cpu_addr_i = 32'h48;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if ({o_mem_req, o_cpu_clk_ce, o_halt} !== 3'b001 ||
                {o_cpu_data_i, o_cpu_data_rd_d} !== {ref_insn, ref_rd}) bad++;
        end
        spurious = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL halt_terminal got %0d bad cycles expected 0 (req=%b ce=%b halt=%b insn=%h)",
                     bad, o_mem_req, o_cpu_clk_ce, o_halt, o_cpu_data_i);
        end
    endtask

    initial begin
        checks = 0; errors = 0; spurious = 1'b0; at_idle = 1'b1;
        fetch_lat = 0; data_lat = 0;
        cpu_addr_i = 32'h0; cpu_addr_d = 32'h0; cpu_rd_d = 1'b0; cpu_wr_d = 4'b0000; cpu_data_wr_d = 32'h0;
        ref_insn = 32'h0; ref_rd = 32'h0; ref_err = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        rst_n = 1'b0;
        test_reset();
        test_addi_loop();
        test_store();
        test_delayed_load();
        test_ack_at_limit();
        test_spurious_ack();
        test_random();
        test_timeout();
        test_reset_mid_data();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
